// File: rtl/reg_pipe_pkg.sv
// Shared definitions for the reg_pipe_hs skid-buffer pipeline: stage state
// encoding and the width helper for the optional occupancy counter.
package reg_pipe_pkg;

  localparam logic [1:0] ST_EMPTY = 2'd0;
  localparam logic [1:0] ST_BUSY  = 2'd1;
  localparam logic [1:0] ST_FULL  = 2'd2;

  typedef enum logic [1:0] {
    StEmpty = ST_EMPTY,
    StBusy  = ST_BUSY,
    StFull  = ST_FULL
  } stage_state_e;

  // Counter must represent 0..2*stages inclusive.
  function automatic int unsigned occ_width(input int unsigned stages);
    return $clog2(2 * stages + 1);
  endfunction

endpackage

// File: rtl/reg_pipe_hs_if.sv
// Valid/ready/data handshake bundle used on both sides of reg_pipe_hs.
interface reg_pipe_hs_if #(
  parameter int unsigned DW = 8
);
  logic          valid;
  logic          ready;
  logic [DW-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/reg_pipe_skid.sv
// One skid-buffer stage: main register drives the output, skid register
// catches the word accepted while the consumer stalls.
module reg_pipe_skid
  import reg_pipe_pkg::*;
#(
  parameter int unsigned   DW        = 8,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          clr,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data
);

  stage_state_e  state_q, state_d;
  logic [DW-1:0] main_q, main_d;
  logic [DW-1:0] skid_q, skid_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StEmpty;
      main_q  <= RESET_VAL;
      skid_q  <= RESET_VAL;
    end else begin
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (clr) begin
      state_d = StEmpty;
      main_d  = RESET_VAL;
      skid_d  = RESET_VAL;
    end else begin
      unique case (state_q)
        StEmpty: begin
          if (in_valid) begin
            state_d = StBusy;
            main_d  = in_data;
          end
        end
        StBusy: begin
          if (in_valid && out_ready) begin
            main_d = in_data;
          end else if (in_valid) begin
            state_d = StFull;
            skid_d  = in_data;
          end else if (out_ready) begin
            state_d = StEmpty;
          end
        end
        StFull: begin
          if (out_ready) begin
            state_d = StBusy;
            main_d  = skid_q;
          end
        end
        default: state_d = StEmpty;
      endcase
    end
  end

  // Both handshake outputs come straight from the state register.
  assign in_ready  = (state_q != StFull);
  assign out_valid = (state_q == StBusy) || (state_q == StFull);
  assign out_data  = main_q;

endmodule

// File: rtl/reg_pipe_hs.sv
// STAGES-deep chain of skid stages with registered ready on every stage.
// Define REG_PIPE_OCC_EN to add the registered occupancy output occ.
module reg_pipe_hs
  import reg_pipe_pkg::*;
#(
  parameter int unsigned   DW        = 8,
  parameter int unsigned   STAGES    = 2,
  parameter logic [DW-1:0] RESET_VAL = '0
) (
  input logic clk,
  input logic reset_n,
  input logic clr,
  reg_pipe_hs_if.slave  s,
  reg_pipe_hs_if.master m
`ifdef REG_PIPE_OCC_EN
  ,
  output logic [occ_width(STAGES)-1:0] occ
`endif
);

  // Link k is the input of stage k; link STAGES is the pipe output.
  logic          vld [STAGES+1];
  logic          rdy [STAGES+1];
  logic [DW-1:0] dat [STAGES+1];

  assign vld[0]      = s.valid;
  assign dat[0]      = s.data;
  assign s.ready     = rdy[0];
  assign m.valid     = vld[STAGES];
  assign m.data      = dat[STAGES];
  assign rdy[STAGES] = m.ready;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    reg_pipe_skid #(
      .DW       (DW),
      .RESET_VAL(RESET_VAL)
    ) u_stage (
      .clk      (clk),
      .reset_n  (reset_n),
      .clr      (clr),
      .in_valid (vld[k]),
      .in_ready (rdy[k]),
      .in_data  (dat[k]),
      .out_valid(vld[k+1]),
      .out_ready(rdy[k+1]),
      .out_data (dat[k+1])
    );
  end

`ifdef REG_PIPE_OCC_EN
  localparam int unsigned OccW = occ_width(STAGES);

  logic [OccW-1:0] occ_q, occ_d;
  logic            s_fire, m_fire;

  assign s_fire = s.valid && rdy[0];
  assign m_fire = vld[STAGES] && m.ready;

  always_comb begin
    occ_d = occ_q;
    if (clr) begin
      occ_d = '0;
    end else if (s_fire && !m_fire) begin
      occ_d = occ_q + OccW'(1);
    end else if (!s_fire && m_fire) begin
      occ_d = occ_q - OccW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      occ_q <= '0;
    end else begin
      occ_q <= occ_d;
    end
  end

  assign occ = occ_q;
`endif

endmodule
